// File: rtl/collision_event_if.sv
// ----------------------------------------------------------------------------
// collision_event_if
// Purpose : valid/ack event handshake between the collision event scheduler
//           and the game-logic FSM.
// Signals :
//   event_valid  scheduler -> logic : an event is presented
//   event_id     scheduler -> logic : class index of the presented event
//   event_ack    logic -> scheduler : current event consumed
// Modports: master = scheduler side, slave = game-logic side.
// ----------------------------------------------------------------------------
interface collision_event_if #(
   parameter int unsigned ID_W = 2
);
   logic            event_valid;
   logic [ID_W-1:0] event_id;
   logic            event_ack;

   modport master (
      output event_valid,
      output event_id,
      input  event_ack
   );

   modport slave (
      input  event_valid,
      input  event_id,
      output event_ack
   );
endinterface

// File: rtl/collision_event_scheduler.sv
// ----------------------------------------------------------------------------
// collision_event_scheduler
// Purpose : accumulates per-frame Ball/object overlaps, snapshots them at
//           start of frame into a pending mask and issues one event per
//           pending class by fixed priority (index 0 highest) over valid/ack.
// Ports   :
//   clk                   system clock
//   resetN                asynchronous active-low reset
//   startOfFrame          one-cycle pulse at start of each frame
//   drawing_request_Ball  Ball pixel is being drawn
//   drawing_request_objs  per-class pixel drawing requests [NUM_SRC]
//   ev (master)           event_valid / event_id out, event_ack in
//   frame_hit_mask        snapshot of the last completed frame's hits
//   overrun               one-cycle pulse when a snapshot lands on pending events
// Option  : define COLLISION_COOLDOWN_EN to add per-class cooldown counters
//           that mask a class for COOLDOWN_FRAMES frames after its event is acked.
// ----------------------------------------------------------------------------
module collision_event_scheduler #(
   parameter int unsigned NUM_SRC         = 4,
   parameter int unsigned ID_W            = 2,
   parameter int unsigned COOLDOWN_FRAMES = 8
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic                 drawing_request_Ball,
   input  logic [NUM_SRC-1:0]   drawing_request_objs,
   collision_event_if.master    ev,
   output logic [NUM_SRC-1:0]   frame_hit_mask,
   output logic                 overrun
);

   localparam int unsigned CD_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t               r_state;
   logic [NUM_SRC-1:0]   r_accum;
   logic [NUM_SRC-1:0]   r_pending;
   logic [NUM_SRC-1:0]   r_frame_hit_mask;
   logic                 r_overrun;
   logic                 r_event_valid;
   logic [ID_W-1:0]      r_event_id;

   logic [NUM_SRC-1:0]   w_cool_mask;
   logic [NUM_SRC-1:0]   w_hit_vec;
   logic [NUM_SRC-1:0]   w_snapshot;
   logic                 w_acked;
   logic [NUM_SRC-1:0]   w_acked_bit;
   logic [NUM_SRC-1:0]   w_pend_kept;
   logic [NUM_SRC-1:0]   w_pend_next;
   logic [ID_W-1:0]      w_sel_id;

   // Hit detection and the frame snapshot (same-cycle hits close the ending frame)
   assign w_hit_vec  = drawing_request_objs & {NUM_SRC{drawing_request_Ball}} & ~w_cool_mask;
   assign w_snapshot = r_accum | w_hit_vec;

   // Acks only count while an event is actually presented
   assign w_acked     = (r_state == S_ISSUE) && ev.event_ack;
   assign w_acked_bit = w_acked ? (NUM_SRC'(1) << r_event_id) : '0;
   assign w_pend_kept = r_pending & ~w_acked_bit;
   assign w_pend_next = w_pend_kept | (startOfFrame ? w_snapshot : '0);

   // Lowest set pending bit wins
   always_comb begin
      w_sel_id = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (r_pending[i]) w_sel_id = ID_W'(i);
      end
   end

`ifdef COLLISION_COOLDOWN_EN
   logic [CD_W-1:0] r_cd [NUM_SRC];

   // Cooldown counters: load on ack (wins), otherwise count frames down to zero
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < int'(NUM_SRC); i++) r_cd[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (w_acked && (r_event_id == ID_W'(i)))
               r_cd[i] <= CD_W'(COOLDOWN_FRAMES);
            else if (startOfFrame && (r_cd[i] != '0))
               r_cd[i] <= r_cd[i] - CD_W'(1);
         end
      end
   end

   always_comb begin
      w_cool_mask = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) w_cool_mask[i] = (r_cd[i] != '0);
   end
`else
   logic [CD_W-1:0] w_unused_cooldown;
   assign w_unused_cooldown = CD_W'(COOLDOWN_FRAMES);
   assign w_cool_mask       = '0;
`endif

   // Frame accumulator, snapshot, pending mask and overrun pulse
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_accum          <= '0;
         r_pending        <= '0;
         r_frame_hit_mask <= '0;
         r_overrun        <= 1'b0;
      end else begin
         r_pending <= w_pend_next;
         if (startOfFrame) begin
            r_accum          <= '0;
            r_frame_hit_mask <= w_snapshot;
            r_overrun        <= (w_pend_kept != '0) && (w_snapshot != '0);
         end else begin
            r_accum   <= r_accum | w_hit_vec;
            r_overrun <= 1'b0;
         end
      end
   end

   // Issue FSM; GAP also performs the next selection so back-to-back
   // events see exactly one valid-low cycle after the ack cycle
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state       <= S_IDLE;
         r_event_valid <= 1'b0;
         r_event_id    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_GAP: begin
               r_event_valid <= 1'b0;
               r_state       <= S_IDLE;
               if (r_pending != '0) begin
                  r_event_id    <= w_sel_id;
                  r_event_valid <= 1'b1;
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (ev.event_ack) begin
                  r_event_valid <= 1'b0;
                  r_state       <= S_GAP;
               end
            end
            default: begin
               r_event_valid <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   assign ev.event_valid = r_event_valid;
   assign ev.event_id    = r_event_id;
   assign frame_hit_mask = r_frame_hit_mask;
   assign overrun        = r_overrun;

endmodule

// File: tb/tb_collision_event_scheduler.sv
// ----------------------------------------------------------------------------
// tb_collision_event_scheduler
// Purpose : directed self-checking bench for collision_event_scheduler.
// ----------------------------------------------------------------------------
module tb_collision_event_scheduler;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned ID_W    = 2;

`ifdef COLLISION_COOLDOWN_EN
   localparam bit CD_ON = 1'b1;
`else
   localparam bit CD_ON = 1'b0;
`endif

   logic               clk;
   logic               resetN;
   logic               sof;
   logic               ball;
   logic [NUM_SRC-1:0] objs;
   logic [NUM_SRC-1:0] fhm;
   logic               ovr;

   int n_pass  = 0;
   int n_total = 0;

   collision_event_if #(.ID_W(ID_W)) ev_if ();

   collision_event_scheduler #(
      .NUM_SRC        (NUM_SRC),
      .ID_W           (ID_W),
      .COOLDOWN_FRAMES(3)
   ) dut (
      .clk                 (clk),
      .resetN              (resetN),
      .startOfFrame        (sof),
      .drawing_request_Ball(ball),
      .drawing_request_objs(objs),
      .ev                  (ev_if.master),
      .frame_hit_mask      (fhm),
      .overrun             (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock; sample/drive 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      resetN         = 1'b0;
      sof            = 1'b0;
      ball           = 1'b0;
      objs           = '0;
      ev_if.event_ack = 1'b0;
      step(2);
      resetN = 1'b1;
      tick();
   endtask

   task automatic hit(input logic [NUM_SRC-1:0] m, input int n);
      ball = 1'b1;
      objs = m;
      step(n);
      ball = 1'b0;
      objs = '0;
   endtask

   task automatic sof_pulse();
      sof = 1'b1;
      tick();
      sof = 1'b0;
   endtask

   task automatic ack_pulse();
      ev_if.event_ack = 1'b1;
      tick();
      ev_if.event_ack = 1'b0;
   endtask

   task automatic no_event(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         tick();
         if (ev_if.event_valid !== 1'b0) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic stable;
      logic exp_v;

      // Reset with random inputs
      resetN          = 1'b0;
      sof             = 1'b0;
      ball            = 1'b0;
      objs            = '0;
      ev_if.event_ack = 1'b0;
      repeat (4) begin
         ball            = 1'($urandom_range(0, 1));
         objs            = NUM_SRC'($urandom_range(0, 15));
         sof             = 1'($urandom_range(0, 1));
         ev_if.event_ack = 1'($urandom_range(0, 1));
         tick();
      end
      chk("rst_valid", 32'(ev_if.event_valid), 32'd0);
      chk("rst_id",    32'(ev_if.event_id),    32'd0);
      chk("rst_fhm",   32'(fhm),               32'd0);
      chk("rst_ovr",   32'(ovr),               32'd0);
      sof = 1'b0; ball = 1'b0; objs = '0; ev_if.event_ack = 1'b0;
      resetN = 1'b1;
      no_event("rst_release_idle", 4);
      chk("rst_release_fhm", 32'(fhm), 32'd0);

      // Single hit: class 2
      hit(4'b0100, 5);
      sof_pulse();
      chk("single_fhm",    32'(fhm),               32'h4);
      chk("single_lat1",   32'(ev_if.event_valid), 32'd0);
      chk("single_ovr",    32'(ovr),               32'd0);
      tick();
      chk("single_valid",  32'(ev_if.event_valid), 32'd1);
      chk("single_id",     32'(ev_if.event_id),    32'd2);
      ack_pulse();
      chk("single_drop",   32'(ev_if.event_valid), 32'd0);
      no_event("single_no_more", 8);

      // Priority 1 before 3, stable id, late higher-priority snapshot waits
      do_reset();
      hit(4'b1010, 3);
      sof_pulse();
      chk("prio_fhm", 32'(fhm), 32'ha);
      tick();
      stable = 1'b1;
      repeat (20) begin
         if (ev_if.event_valid !== 1'b1 || ev_if.event_id !== 2'd1) stable = 1'b0;
         tick();
      end
      chk("prio_stable", 32'(stable), 32'd1);
      hit(4'b0001, 2);
      sof_pulse();
      chk("prio_late_ovr",  32'(ovr),               32'd1);
      chk("prio_hold_id",   32'(ev_if.event_id),    32'd1);
      chk("prio_hold_vld",  32'(ev_if.event_valid), 32'd1);
      ack_pulse();
      chk("prio_gap1",      32'(ev_if.event_valid), 32'd0);
      tick();
      chk("prio_ev2_valid", 32'(ev_if.event_valid), 32'd1);
      chk("prio_ev2_id",    32'(ev_if.event_id),    32'd0);
      ack_pulse();
      chk("prio_gap2",      32'(ev_if.event_valid), 32'd0);
      tick();
      chk("prio_ev3_valid", 32'(ev_if.event_valid), 32'd1);
      chk("prio_ev3_id",    32'(ev_if.event_id),    32'd3);
      ack_pulse();
      no_event("prio_no_more", 6);

      // Overrun / merge: {0} then {0,2} with no ack in between
      do_reset();
      hit(4'b0001, 2);
      sof_pulse();
      chk("ovr_first_none", 32'(ovr), 32'd0);
      tick();
      chk("ovr_ev0_id", 32'(ev_if.event_id), 32'd0);
      hit(4'b0101, 2);
      sof_pulse();
      chk("ovr_pulse",   32'(ovr), 32'd1);
      chk("ovr_fhm",     32'(fhm), 32'h5);
      tick();
      chk("ovr_one_cyc", 32'(ovr), 32'd0);
      chk("ovr_id0_held", 32'(ev_if.event_id), 32'd0);
      ack_pulse();
      tick();
      chk("ovr_ev2_valid", 32'(ev_if.event_valid), 32'd1);
      chk("ovr_ev2_id",    32'(ev_if.event_id),    32'd2);
      ack_pulse();
      no_event("ovr_no_third", 8);

      // Ack on the startOfFrame cycle that re-hits the same class
      do_reset();
      hit(4'b0010, 2);
      sof_pulse();
      tick();
      chk("ackcol_id", 32'(ev_if.event_id), 32'd1);
      hit(4'b0010, 2);
      ev_if.event_ack = 1'b1;
      sof = 1'b1;
      tick();
      ev_if.event_ack = 1'b0;
      sof = 1'b0;
      chk("ackcol_gap",  32'(ev_if.event_valid), 32'd0);
      chk("ackcol_ovr",  32'(ovr),               32'd0);
      chk("ackcol_fhm",  32'(fhm),               32'h2);
      tick();
      chk("ackcol_reissue_valid", 32'(ev_if.event_valid), 32'd1);
      chk("ackcol_reissue_id",    32'(ev_if.event_id),    32'd1);

      // Reset mid-ISSUE discards the event immediately
      resetN = 1'b0;
      #1;
      chk("midrst_valid", 32'(ev_if.event_valid), 32'd0);
      chk("midrst_fhm",   32'(fhm),               32'd0);
      step(2);
      resetN = 1'b1;
      no_event("midrst_no_replay", 6);

      // Cooldown: class 0 hit every frame after an ack
      do_reset();
      hit(4'b0001, 2);
      sof_pulse();
      tick();
      chk("cd_first_id", 32'(ev_if.event_id), 32'd0);
      ack_pulse();
      tick();
      for (int f = 1; f <= 4; f++) begin
         hit(4'b0001, 2);
         sof_pulse();
         tick();
         exp_v = CD_ON ? (f == 4) : 1'b1;
         chk($sformatf("cd_frame%0d_valid", f), 32'(ev_if.event_valid), 32'(exp_v));
         if (ev_if.event_valid === 1'b1) begin
            ack_pulse();
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
